// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory read path and the loader.
// Covers the SRAM geometry and the loader FSM state encoding.
package imem_pkg;
  localparam int ADDR_W     = 9;
  localparam int HALF_W     = 16;
  localparam int IMEM_DEPTH = 1 << ADDR_W;
  localparam int CNT_W      = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ld_state_e;
endpackage

// File: rtl/imem_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words.
// word_full fires combinationally on the byte that completes a word.
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_full,
  output logic [31:0] word
);
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shreg_q, shreg_d;

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (clr) begin
      cnt_d = 2'd0;
    end else if (in_valid) begin
      cnt_d   = cnt_q + 2'd1;
      // Shift in from the top so byte 0 ends up in the least significant lane.
      shreg_d = {in_data, shreg_q[23:8]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      shreg_q <= 24'd0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  assign word_full = in_valid && !clr && (cnt_q == 2'd3);
  assign word      = {in_data, shreg_q};
endmodule

// File: rtl/imem_loader.sv
// Streams bytes into the two 512x16 instruction SRAM halves while stalling the CPU.
// All outputs are registered; the async reset forces the SRAM strobes inactive at once.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = imem_pkg::ADDR_W,
  parameter int HALF_W = imem_pkg::HALF_W,
  parameter int CNT_W  = imem_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [HALF_W-1:0] mem_d_low,
  output logic [HALF_W-1:0] mem_d_high,
  output logic              cpu_stall,
  output logic              done,
  output logic              err
);
  localparam int DEPTH = 1 << ADDR_W;

  ld_state_e         state_q, state_d;
  logic              byte_ready_q, byte_ready_d;
  logic              cen_q, cen_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [HALF_W-1:0] dlo_q, dlo_d;
  logic [HALF_W-1:0] dhi_q, dhi_d;
  logic              stall_q, stall_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  wcnt_inc;

  logic              accept;
  logic              pack_clr;
  logic              word_full;
  logic [31:0]       pack_word;

  assign accept   = byte_valid && byte_ready_q;
  assign pack_clr = (state_q == IDLE) && start;

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pack_clr),
    .in_valid  (accept),
    .in_data   (byte_data),
    .word_full (word_full),
    .word      (pack_word)
  );

  always_comb begin
    state_d      = state_q;
    byte_ready_d = 1'b0;
    cen_d        = 1'b1;
    wen_d        = 1'b1;
    addr_d       = addr_q;
    dlo_d        = dlo_q;
    dhi_d        = dhi_q;
    done_d       = 1'b0;
    err_d        = err_q;
    num_d        = num_q;
    wcnt_d       = wcnt_q;
    wcnt_inc     = wcnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d  = num_words;
          err_d  = 1'b0;
          wcnt_d = '0;
          if (num_words == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (num_words > CNT_W'(DEPTH)) begin
            err_d   = 1'b1;
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d      = RECV;
            byte_ready_d = 1'b1;
          end
        end
      end
      RECV: begin
        // The completing byte is folded in directly, so the write issues next cycle.
        if (word_full) begin
          state_d = WRITE;
          cen_d   = 1'b0;
          wen_d   = 1'b0;
          addr_d  = wcnt_q[ADDR_W-1:0];
          dlo_d   = pack_word[HALF_W-1:0];
          dhi_d   = pack_word[2*HALF_W-1:HALF_W];
        end else begin
          byte_ready_d = 1'b1;
        end
      end
      WRITE: begin
        wcnt_d = wcnt_inc;
        if (wcnt_inc == num_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d      = RECV;
          byte_ready_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      byte_ready_q <= 1'b0;
      cen_q        <= 1'b1;
      wen_q        <= 1'b1;
      addr_q       <= '0;
      dlo_q        <= '0;
      dhi_q        <= '0;
      stall_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      num_q        <= '0;
      wcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= byte_ready_d;
      cen_q        <= cen_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      dlo_q        <= dlo_d;
      dhi_q        <= dhi_d;
      stall_q      <= stall_d;
      done_q       <= done_d;
      err_q        <= err_d;
      num_q        <= num_d;
      wcnt_q       <= wcnt_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_cen    = cen_q;
  assign mem_wen    = wen_q;
  assign mem_addr   = addr_q;
  assign mem_d_low  = dlo_q;
  assign mem_d_high = dhi_q;
  assign cpu_stall  = stall_q;
  assign done       = done_q;
  assign err        = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a behavioural 512x32 SRAM model for read-back.
module tb_imem_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [9:0] num_words = '0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic       byte_ready;
  logic       mem_cen;
  logic       mem_wen;
  logic [8:0] mem_addr;
  logic [15:0] mem_d_low;
  logic [15:0] mem_d_high;
  logic       cpu_stall;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0;
  int wr_cnt = 0;
  int cen_lo_cnt = 0;
  int wen_mis = 0;
  int rdy_in_wr = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_wr_cyc = 0;
  logic [8:0]  wr_addr [1024];
  logic [31:0] wr_data [1024];
  logic [15:0] mem_lo [512];
  logic [15:0] mem_hi [512];

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_cen    (mem_cen),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_d_low  (mem_d_low),
    .mem_d_high (mem_d_high),
    .cpu_stall  (cpu_stall),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // SRAM model and write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_cen != mem_wen) wen_mis <= wen_mis + 1;
    if (!mem_cen) begin
      cen_lo_cnt <= cen_lo_cnt + 1;
      if (!mem_wen) begin
        wr_addr[wr_cnt % 1024] <= mem_addr;
        wr_data[wr_cnt % 1024] <= {mem_d_high, mem_d_low};
        wr_cnt      <= wr_cnt + 1;
        last_wr_cyc <= cyc;
        mem_lo[mem_addr] <= mem_d_low;
        mem_hi[mem_addr] <= mem_d_high;
        if (byte_ready) rdy_in_wr <= rdy_in_wr + 1;
      end
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [9:0] n);
    start = 1'b1;
    num_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL send_byte_timeout: byte_ready=%b required 1", byte_ready);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (done !== 1'b1 && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= budget) begin
      n_cmp++; n_err++;
      $display("FAIL wait_done_timeout: done=%b required 1", done);
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (byte_ready !== 1'b0) begin n_err++; $display("FAIL rst_byte_ready: got %b want 0", byte_ready); end
    n_cmp++; if (mem_cen !== 1'b1) begin n_err++; $display("FAIL rst_cen: got %b want 1", mem_cen); end
    n_cmp++; if (mem_wen !== 1'b1) begin n_err++; $display("FAIL rst_wen: got %b want 1", mem_wen); end
    n_cmp++; if (mem_addr !== 9'd0) begin n_err++; $display("FAIL rst_addr: got %0d want 0", mem_addr); end
    n_cmp++; if ({mem_d_high, mem_d_low} !== 32'd0) begin n_err++; $display("FAIL rst_data: got %h want 0", {mem_d_high, mem_d_low}); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", cpu_stall); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_two_word;
    int b0, d0, c0;
    b0 = wr_cnt; d0 = done_cnt; c0 = cen_lo_cnt;
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL two_stall_idle: got %b want 0", cpu_stall); end
    pulse_start(10'd2);
    n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL two_stall_recv: got %b want 1", cpu_stall); end
    n_cmp++; if (byte_ready !== 1'b1) begin n_err++; $display("FAIL two_ready_recv: got %b want 1", byte_ready); end
    send_word(32'h0050_0013);
    send_word(32'h0010_0093);
    wait_done(20);
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL two_done_width: got %b want 0", done); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL two_stall_end: got %b want 0", cpu_stall); end
    n_cmp++; if (wr_cnt - b0 !== 2) begin n_err++; $display("FAIL two_wr_count: got %0d want 2", wr_cnt - b0); end
    n_cmp++; if (cen_lo_cnt - c0 !== 2) begin n_err++; $display("FAIL two_cen_cycles: got %0d want 2", cen_lo_cnt - c0); end
    n_cmp++; if (wen_mis !== 0) begin n_err++; $display("FAIL two_wen_eq_cen: got %0d want 0", wen_mis); end
    n_cmp++; if (wr_addr[b0] !== 9'd0 || wr_data[b0] !== 32'h0050_0013) begin
      n_err++; $display("FAIL two_wr0: got addr %0d data %h want addr 0 data 00500013", wr_addr[b0], wr_data[b0]);
    end
    n_cmp++; if (wr_addr[b0+1] !== 9'd1 || wr_data[b0+1] !== 32'h0010_0093) begin
      n_err++; $display("FAIL two_wr1: got addr %0d data %h want addr 1 data 00100093", wr_addr[b0+1], wr_data[b0+1]);
    end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL two_done_pulses: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (done_cyc !== last_wr_cyc + 1) begin n_err++; $display("FAIL two_done_latency: got %0d want %0d", done_cyc, last_wr_cyc + 1); end
  endtask

  task automatic test_zero_words;
    int b0, c0;
    b0 = wr_cnt; c0 = cen_lo_cnt;
    pulse_start(10'd0);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b want 1", done); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL zero_err: got %b want 0", err); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0 || cpu_stall !== 1'b0) begin
      n_err++; $display("FAIL zero_back_idle: got done %b stall %b want 0 0", done, cpu_stall);
    end
    n_cmp++; if (cen_lo_cnt - c0 !== 0 || wr_cnt - b0 !== 0) begin
      n_err++; $display("FAIL zero_no_write: got %0d cen-low cycles want 0", cen_lo_cnt - c0);
    end
  endtask

  task automatic test_overflow;
    int b0;
    b0 = wr_cnt;
    pulse_start(10'd513);
    n_cmp++; if (err !== 1'b1 || done !== 1'b1) begin
      n_err++; $display("FAIL ovf_err_done: got err %b done %b want 1 1", err, done);
    end
    @(posedge clk); #1; @(posedge clk); #1;
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", err); end
    n_cmp++; if (wr_cnt - b0 !== 0) begin n_err++; $display("FAIL ovf_no_write: got %0d want 0", wr_cnt - b0); end
    pulse_start(10'd1);
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", err); end
    send_word(32'h0403_0201);
    wait_done(20);
    n_cmp++; if (wr_cnt - b0 !== 1 || wr_addr[b0] !== 9'd0 || wr_data[b0] !== 32'h0403_0201) begin
      n_err++; $display("FAIL ovf_reload: got %0d writes addr %0d data %h want 1 0 04030201", wr_cnt - b0, wr_addr[b0], wr_data[b0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int b0, r0, idx;
    logic [6:0]  pat;
    logic [31:0] w;
    logic        acc;
    b0 = wr_cnt; r0 = rdy_in_wr;
    pat = 7'b1011001;
    w = 32'hDEAD_BEEF;
    idx = 0;
    pulse_start(10'd1);
    for (int i = 0; i < 7; i++) begin
      byte_valid = pat[i];
      byte_data  = (idx < 4) ? w[8*idx +: 8] : 8'h00;
      acc = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    byte_valid = 1'b0;
    n_cmp++; if (idx !== 4) begin n_err++; $display("FAIL bp_accepted: got %0d want 4", idx); end
    wait_done(20);
    n_cmp++; if (wr_cnt - b0 !== 1 || wr_data[b0] !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL bp_write: got %0d writes data %h want 1 deadbeef", wr_cnt - b0, wr_data[b0]);
    end
    n_cmp++; if (rdy_in_wr - r0 !== 0) begin n_err++; $display("FAIL bp_ready_in_write: got %0d want 0", rdy_in_wr - r0); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_depth;
    int b0, zero_hits;
    logic [31:0] exp;
    b0 = wr_cnt;
    pulse_start(10'd512);
    for (int k = 0; k < 512; k++) send_word({16'(16'h1000 + k), 16'(k)});
    wait_done(50);
    @(posedge clk); #1;
    n_cmp++; if (wr_cnt - b0 !== 512) begin n_err++; $display("FAIL full_count: got %0d want 512", wr_cnt - b0); end
    n_cmp++; if (wr_addr[(b0 + 511) % 1024] !== 9'd511) begin
      n_err++; $display("FAIL full_last_addr: got %0d want 511", wr_addr[(b0 + 511) % 1024]);
    end
    zero_hits = 0;
    for (int k = 0; k < 512; k++) if (wr_addr[(b0 + k) % 1024] == 9'd0) zero_hits++;
    n_cmp++; if (zero_hits !== 1) begin n_err++; $display("FAIL full_addr0_hits: got %0d want 1", zero_hits); end
    for (int a = 0; a < 512; a++) begin
      exp = {16'(16'h1000 + a), 16'(a)};
      n_cmp++;
      if ({mem_hi[a], mem_lo[a]} !== exp) begin
        n_err++; $display("FAIL full_readback[%0d]: got %h want %h", a, {mem_hi[a], mem_lo[a]}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_load;
    int b0;
    b0 = wr_cnt;
    pulse_start(10'd5);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    send_byte(8'h44);
    send_byte(8'h55);
    byte_valid = 1'b1;
    byte_data  = 8'h66;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_cen !== 1'b1 || mem_wen !== 1'b1) begin
      n_err++; $display("FAIL mid_rst_strobes: got cen %b wen %b want 1 1", mem_cen, mem_wen);
    end
    n_cmp++; if (byte_ready !== 1'b0 || cpu_stall !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_ctrl: got ready %b stall %b want 0 0", byte_ready, cpu_stall);
    end
    n_cmp++; if (mem_addr !== 9'd0 || {mem_d_high, mem_d_low} !== 32'd0) begin
      n_err++; $display("FAIL mid_rst_addr_data: got addr %0d data %h want 0 0", mem_addr, {mem_d_high, mem_d_low});
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (wr_cnt - b0 !== 3) begin n_err++; $display("FAIL mid_rst_writes: got %0d want 3", wr_cnt - b0); end
    rst_n = 1'b1;
    byte_valid = 1'b0;
    @(posedge clk); #1;
    pulse_start(10'd1);
    send_word(32'hDDCC_BBAA);
    wait_done(20);
    n_cmp++; if (wr_cnt - b0 !== 4 || wr_addr[b0 + 3] !== 9'd0 || wr_data[b0 + 3] !== 32'hDDCC_BBAA) begin
      n_err++; $display("FAIL mid_rst_fresh: got %0d writes addr %0d data %h want 4 0 ddccbbaa", wr_cnt - b0, wr_addr[b0 + 3], wr_data[b0 + 3]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_zero_words();
    test_overflow();
    test_backpressure();
    test_full_depth();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction memory read path.
- Receives a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit instructions.
- Writes each instruction into the two 512x16 instruction SRAM halves (low/high) through their active-low CEN/WEN pins, at consecutive word addresses starting at 0.
- Holds the CPU in stall for the whole load.

Parameters:
- ADDR_W, 9, word-address width; depth = 2**ADDR_W = 512.
- HALF_W, 16, width of each SRAM half; instruction width = 2*HALF_W = 32.
- CNT_W, 10, width of num_words; must be ADDR_W+1 so the value 512 fits.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  load request; sampled only in IDLE.
- num_words  in  CNT_W  number of instructions to load; sampled with start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_cen  out  1  SRAM chip enable, active-low; shared by both halves.
- mem_wen  out  1  SRAM write enable, active-low; shared by both halves.
- mem_addr  out  ADDR_W  SRAM word address.
- mem_d_low  out  HALF_W  write data, bits [15:0] of the instruction.
- mem_d_high  out  HALF_W  write data, bits [31:16] of the instruction.
- cpu_stall  out  1  high while the loader is not IDLE.
- done  out  1  one-cycle pulse at end of load.
- err  out  1  sticky; set when num_words > 512; cleared by the next accepted start.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; byte_ready=0; mem_cen=1; mem_wen=1; mem_addr=0; mem_d_low=0; mem_d_high=0; cpu_stall=0; done=0; err=0.
  - Byte counter and word counter are cleared.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE:
  - On start=1, latch num_words, clear err and word counter.
  - If num_words==0: go to DONE.
  - If num_words>512: set err, go to DONE.
  - Otherwise: go to RECV.
- RECV:
  - byte_ready=1. A byte is accepted when byte_valid && byte_ready.
  - Byte k (k=0..3) of the current word goes to instruction bits [8k+7:8k].
  - The 2-bit byte counter increments on each accepted byte.
  - On acceptance of byte 3, go to WRITE.
  - Gaps in byte_valid stall progress with no timeout.
- WRITE (exactly one cycle):
  - byte_ready=0; mem_cen=0; mem_wen=0; mem_addr = word counter; mem_d_high/mem_d_low = packed word.
  - Word counter increments.
  - If the incremented count == num_words, go to DONE; else go to RECV.
- DONE (one cycle): done=1, then go to IDLE.
- Outside WRITE: mem_cen=1, mem_wen=1. mem_addr and data hold their last values; they are don't-care for the SRAM.
- Throughput: 5 cycles per word minimum (4 RECV + 1 WRITE).
- Latency: done is asserted the cycle after the last WRITE.
- cpu_stall is high in RECV, WRITE and DONE. It is low in IDLE and on the cycle start is sampled. It is registered from state.
- start outside IDLE is ignored.
- A byte_valid pulse outside RECV is not consumed, because byte_ready=0.
- Address boundary: a 512-word load ends with a write at addr 511. The address never wraps to 0.
- Reset mid-operation: the partial word is discarded and no further SRAM write is issued. The asynchronous reset forces mem_cen and mem_wen high immediately, even in WRITE.

Decomposition:
- Shared package (e.g. imem_pkg): ADDR_W, HALF_W, IMEM_DEPTH=512, and the loader state enum {IDLE, RECV, WRITE, DONE}. The instruction memory read path and the loader both use this package.
- One natural sub-module: imem_byte_packer (2-bit byte counter plus 32-bit shift/pack register, with a word_full strobe).
- FSM, word counter and SRAM drive stay in imem_loader.

Test Plan:
- Two-word load: start, num_words=2, bytes 13 00 50 00 93 00 10 00 sent back-to-back.
  - Write at addr 0 with d_high=0x0050, d_low=0x0013.
  - Write at addr 1 with d_high=0x0010, d_low=0x0093.
  - Each write has CEN=WEN=0 for exactly 1 cycle; done pulses 1 cycle after the second write; cpu_stall drops with the return to IDLE.
- num_words=0: done pulses in the cycle after start; no CEN low ever; err=0.
- num_words=513: err=1, done pulses, zero writes. A following start with num_words=1 clears err.
- Backpressure: byte_valid toggles 1-0-0-1-1-0-1 for one word of bytes EF BE AD DE.
  - Exactly one write, data 0xDEADBEEF (high=0xDEAD, low=0xBEEF).
  - byte_ready=0 throughout the WRITE cycle.
- Full depth: num_words=512 with an incrementing pattern.
  - 512 writes, last at addr 511; no write to addr 0 after the first.
  - Read-back through the instruction memory matches every word.
- Reset mid-load: rst_n=0 after 2 bytes of word 3.
  - Outputs return to reset values asynchronously; no write for word 3.
  - A fresh load after reset starts at addr 0.
